// File: rtl/keypad_pkg.sv
// Shared types for the keypad entry path: BCD digit type and entry FSM states.
package keypad_pkg;
    localparam int BCD_W = 4;
    typedef logic [BCD_W-1:0] bcd_t;
    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        DISABLED,
        IDLE,
        PRESS,
        RELEASE
    } kp_state_e;
endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry signal bundle: encoder samples and FSM controls in, cook-time digits out.
// entry_timeout exists only when KEYPAD_CTRL_TIMEOUT_EN is defined.
interface keypad_entry_ctrl_if;
    import keypad_pkg::*;

    bcd_t bcd;
    logic data_valid;
    logic entry_enn;
    logic clear;
    logic encoder_enablen;
    bcd_t sec_ones;
    bcd_t sec_tens;
    bcd_t min_ones;
    logic key_strobe;
    logic entry_nonzero;
`ifdef KEYPAD_CTRL_TIMEOUT_EN
    logic entry_timeout;
`endif

    modport master (
        output bcd, data_valid, entry_enn, clear,
        input  encoder_enablen, sec_ones, sec_tens, min_ones, key_strobe, entry_nonzero
`ifdef KEYPAD_CTRL_TIMEOUT_EN
        , input entry_timeout
`endif
    );

    modport slave (
        input  bcd, data_valid, entry_enn, clear,
        output encoder_enablen, sec_ones, sec_tens, min_ones, key_strobe, entry_nonzero
`ifdef KEYPAD_CTRL_TIMEOUT_EN
        , output entry_timeout
`endif
    );
endinterface

// File: rtl/keypad_debounce_cnt.sv
// Saturating match counter; done flags that one more increment reaches MAX.
module keypad_debounce_cnt #(
    parameter  int unsigned MAX = 4,
    localparam int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         rst,
    input  logic         load1,
    output logic [W-1:0] count,
    output logic         done
);
    localparam logic [W-1:0] MAX_C = W'(MAX);
    localparam logic [W-1:0] MAX_M1 = W'(MAX - 1);

    assign done = (count == MAX_M1);

    always_ff @(posedge clk) begin
        if (!resetn || rst)
            count <= '0;
        else if (load1)
            count <= W'(1);
        else if (inc && count != MAX_C)
            count <= count + W'(1);
    end
endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces encoder samples and shifts digits into an M:SS register.
// Optional idle timeout pulse is built when KEYPAD_CTRL_TIMEOUT_EN is defined.
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input logic clk,
    input logic resetn,
    keypad_entry_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    bcd_t      r_bcd_q;
    logic      r_valid_q;
    kp_state_e r_state;
    bcd_t      r_cand;
    bcd_t      r_sec_ones, r_sec_tens, r_min_ones;
    logic      r_key_strobe, r_entry_nonzero, r_encoder_enablen;

    logic          w_key, w_match, w_accept, w_done;
    logic          w_inc, w_rst, w_load1;
    logic [CW-1:0] w_count;
    bcd_t          w_so_nxt, w_st_nxt, w_mo_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_bcd_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_bcd_q   <= bus.bcd;
            r_valid_q <= bus.data_valid;
        end
    end

    // Encoder codes above 9 are treated exactly like no key pressed.
    assign w_key    = r_valid_q && (r_bcd_q <= BCD_MAX);
    assign w_match  = w_key && (r_bcd_q == r_cand);
    assign w_accept = !bus.entry_enn && (r_state == PRESS) && w_match && w_done;

    always_comb begin
        w_inc   = 1'b0;
        w_rst   = 1'b0;
        w_load1 = 1'b0;
        if (bus.entry_enn) begin
            w_rst = 1'b1;
        end else begin
            case (r_state)
                DISABLED: w_rst = 1'b1;
                IDLE:     w_load1 = w_key;
                PRESS: begin
                    if (w_match) begin
                        w_rst = w_done;
                        w_inc = !w_done;
                    end else if (w_key) begin
                        w_load1 = 1'b1;
                    end else begin
                        w_rst = 1'b1;
                    end
                end
                RELEASE: begin
                    w_rst = w_key;
                    w_inc = !w_key;
                end
                default: w_rst = 1'b1;
            endcase
        end
    end

    keypad_debounce_cnt #(.MAX(DEBOUNCE_CYCLES)) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_inc),
        .rst    (w_rst),
        .load1  (w_load1),
        .count  (w_count),
        .done   (w_done)
    );

    // Clear overrides a coincident accept; the strobe still fires.
    always_comb begin
        w_so_nxt = r_sec_ones;
        w_st_nxt = r_sec_tens;
        w_mo_nxt = r_min_ones;
        if (w_accept) begin
            w_mo_nxt = r_sec_tens;
            w_st_nxt = r_sec_ones;
            w_so_nxt = r_cand;
        end
        if (bus.clear) begin
            w_so_nxt = '0;
            w_st_nxt = '0;
            w_mo_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state           <= DISABLED;
            r_cand            <= '0;
            r_sec_ones        <= '0;
            r_sec_tens        <= '0;
            r_min_ones        <= '0;
            r_key_strobe      <= 1'b0;
            r_entry_nonzero   <= 1'b0;
            r_encoder_enablen <= 1'b1;
        end else begin
            r_encoder_enablen <= bus.entry_enn;
            r_key_strobe      <= w_accept;
            r_sec_ones        <= w_so_nxt;
            r_sec_tens        <= w_st_nxt;
            r_min_ones        <= w_mo_nxt;
            r_entry_nonzero   <= |{w_so_nxt, w_st_nxt, w_mo_nxt};
            if (bus.entry_enn) begin
                r_state <= DISABLED;
            end else begin
                case (r_state)
                    DISABLED: r_state <= RELEASE;
                    IDLE: if (w_key) begin
                        r_cand  <= r_bcd_q;
                        r_state <= PRESS;
                    end
                    PRESS: begin
                        if (w_accept)
                            r_state <= RELEASE;
                        else if (w_key && !w_match)
                            r_cand <= r_bcd_q;
                        else if (!w_key)
                            r_state <= IDLE;
                    end
                    RELEASE: if (!w_key && w_done) r_state <= IDLE;
                    default: r_state <= DISABLED;
                endcase
            end
        end
    end

    assign bus.encoder_enablen = r_encoder_enablen;
    assign bus.sec_ones        = r_sec_ones;
    assign bus.sec_tens        = r_sec_tens;
    assign bus.min_ones        = r_min_ones;
    assign bus.key_strobe      = r_key_strobe;
    assign bus.entry_nonzero   = r_entry_nonzero;

`ifdef KEYPAD_CTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_idle_cnt;
    logic          r_entry_timeout;

    // Counter parks at TIMEOUT_CYCLES so the pulse fires once per idle period.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_idle_cnt      <= '0;
            r_entry_timeout <= 1'b0;
        end else begin
            r_entry_timeout <= 1'b0;
            if (r_key_strobe || bus.clear) begin
                r_idle_cnt <= '0;
            end else if (r_state == IDLE && r_entry_nonzero &&
                         r_idle_cnt != TW'(TIMEOUT_CYCLES)) begin
                r_idle_cnt <= r_idle_cnt + TW'(1);
                if (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1))
                    r_entry_timeout <= 1'b1;
            end
        end
    end

    assign bus.entry_timeout = r_entry_timeout;
`endif
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl: expected digits queued per press, checked on each strobe.
// Timeout checks run only when KEYPAD_CTRL_TIMEOUT_EN is defined.
module tb_keypad_entry_ctrl;
    import keypad_pkg::*;

    typedef struct packed {
        bcd_t mo;
        bcd_t st;
        bcd_t so;
        logic nz;
    } exp_t;

    logic clk;
    logic resetn;
    keypad_entry_ctrl_if ifc();

    keypad_entry_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   total = 0;
    int   bad = 0;
    int   n_strobe = 0;
    int   n_timeout = 0;
    exp_t sb[$];
    bcd_t m_so = '0, m_st = '0, m_mo = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (resetn && ifc.key_strobe) begin
            exp_t e;
            n_strobe++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL strobe_unexpected: got digits %0h%0h%0h expected no strobe",
                         ifc.min_ones, ifc.sec_tens, ifc.sec_ones);
            end else begin
                e = sb.pop_front();
                if ({ifc.min_ones, ifc.sec_tens, ifc.sec_ones, ifc.entry_nonzero} !== e) begin
                    bad++;
                    $display("FAIL strobe_digits: got %0h%0h%0h nz=%0b expected %0h%0h%0h nz=%0b",
                             ifc.min_ones, ifc.sec_tens, ifc.sec_ones, ifc.entry_nonzero,
                             e.mo, e.st, e.so, e.nz);
                end
            end
        end
`ifdef KEYPAD_CTRL_TIMEOUT_EN
        if (resetn && ifc.entry_timeout) n_timeout++;
`endif
    end

    task automatic expect_digit(input bcd_t d);
        m_mo = m_st;
        m_st = m_so;
        m_so = d;
        sb.push_back('{mo: m_mo, st: m_st, so: m_so, nz: |{m_mo, m_st, m_so}});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_key(input int n);
        ifc.data_valid = 1'b0;
        ifc.bcd = '0;
        cycles(n);
    endtask

    task automatic press(input bcd_t d);
        ifc.bcd = d;
        ifc.data_valid = 1'b1;
        cycles(6);
        release_key(6);
    endtask

    task automatic chk_digits(input string name);
        chk(name, {ifc.min_ones, ifc.sec_tens, ifc.sec_ones, 3'b000, ifc.entry_nonzero},
            {m_mo, m_st, m_so, 3'b000, |{m_mo, m_st, m_so}});
    endtask

    initial begin
        int s0;
        resetn = 1'b0;
        ifc.bcd = '0;
        ifc.data_valid = 1'b0;
        ifc.entry_enn = 1'b1;
        ifc.clear = 1'b0;
        cycles(3);
        chk("reset_digits", {ifc.min_ones, ifc.sec_tens, ifc.sec_ones}, 0);
        chk("reset_strobe", ifc.key_strobe, 0);
        chk("reset_nonzero", ifc.entry_nonzero, 0);
        chk("reset_enablen", ifc.encoder_enablen, 1);
        resetn = 1'b1;
        cycles(1);
        ifc.entry_enn = 1'b0;
        cycles(1);
        chk("grant_enablen", ifc.encoder_enablen, 0);
        cycles(8);

        // Single press of 5
        expect_digit(4'd5);
        press(4'd5);
        chk_digits("t1_digits");

        // 1,2,3,4 -> 2:34
        s0 = n_strobe;
        for (int i = 1; i <= 4; i++) begin
            expect_digit(bcd_t'(i));
            press(bcd_t'(i));
        end
        chk("t2_strobes", n_strobe - s0, 4);
        chk("t2_digits", {ifc.min_ones, ifc.sec_tens, ifc.sec_ones}, 12'h234);

        // Short press: aborted before debounce completes
        ifc.bcd = 4'd9;
        ifc.data_valid = 1'b1;
        cycles(2);
        release_key(6);
        chk_digits("t3_short");
        // Bounce 7 -> 3: only 3 lands
        expect_digit(4'd3);
        ifc.bcd = 4'd7;
        ifc.data_valid = 1'b1;
        cycles(2);
        press(4'd3);
        chk_digits("t3_bounce");

        // Key held across the re-grant must not enter
        ifc.entry_enn = 1'b1;
        ifc.bcd = 4'd5;
        ifc.data_valid = 1'b1;
        cycles(6);
        chk("t4_enablen_hi", ifc.encoder_enablen, 1);
        ifc.entry_enn = 1'b0;
        cycles(10);
        release_key(6);
        chk_digits("t4_held");
        expect_digit(4'd6);
        press(4'd6);

        // Clear coincident with accept: clear wins, strobe still pulses
        m_so = '0; m_st = '0; m_mo = '0;
        sb.push_back('0);
        ifc.bcd = 4'd9;
        ifc.data_valid = 1'b1;
        cycles(4);
        ifc.clear = 1'b1;
        cycles(1);
        ifc.clear = 1'b0;
        cycles(1);
        release_key(6);
        chk_digits("t5_clear");
        // Out-of-range code ignored
        ifc.bcd = 4'd12;
        ifc.data_valid = 1'b1;
        cycles(8);
        release_key(6);
        chk_digits("t5_code12");

`ifdef KEYPAD_CTRL_TIMEOUT_EN
        expect_digit(4'd8);
        press(4'd8);
        chk("t6_no_early_timeout", n_timeout, 0);
        cycles(40);
        chk("t6_timeout_once", n_timeout, 1);
        chk("t6_digit_kept", ifc.sec_ones, 8);
`endif

        // Reset mid-press drops the debounce and zeroes everything
        expect_digit(4'd2);
        press(4'd2);
        chk_digits("t7_pre_reset");
        ifc.bcd = 4'd7;
        ifc.data_valid = 1'b1;
        cycles(3);
        resetn = 1'b0;
        cycles(1);
        chk("t7_reset_digits", {ifc.min_ones, ifc.sec_tens, ifc.sec_ones}, 0);
        chk("t7_reset_nonzero", ifc.entry_nonzero, 0);
        chk("t7_reset_enablen", ifc.encoder_enablen, 1);
        resetn = 1'b1;
        release_key(10);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencing controller for the microwave keypad path. It drives the priority encoder's active-low enable, samples its `bcd`/`data_valid` outputs, and debounces each key press. Each accepted press shifts one digit into a three-digit cook-time register (M:SS). The main microwave FSM grants or revokes entry and can clear the time. The timer block reads the digit outputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive identical samples required to accept a press, and also to accept a release. Legal range is 2..255.
- `TIMEOUT_CYCLES`, default 1000: idle cycles after the last accepted digit before `entry_timeout` pulses. Used only with `KEYPAD_CTRL_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock. All logic uses the rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `bcd` in 4: digit from the priority encoder.
- `data_valid` in 1: encoder reports a key pressed.
- `entry_enn` in 1: active-low entry grant from the main FSM.
- `clear` in 1: synchronous clear of the cook-time digits.
- `encoder_enablen` out 1: registered; drives the encoder's `enablen`.
- `sec_ones` out 4: BCD digit.
- `sec_tens` out 4: BCD digit.
- `min_ones` out 4: BCD digit.
- `key_strobe` out 1: one-cycle pulse per accepted digit.
- `entry_nonzero` out 1: registered; high when any digit is non-zero.
- `entry_timeout` out 1: one-cycle pulse. Present only with `KEYPAD_CTRL_TIMEOUT_EN`.

## Operation
- Input capture: `bcd` and `data_valid` are registered every cycle into `bcd_q`/`valid_q`.
- A sample is a valid key only if `valid_q` = 1 and `bcd_q` <= 9. Values 10..15 count as no key.
- `encoder_enablen` is `entry_enn` delayed by one register.
- FSM states:
  - DISABLED: entered from any state when `entry_enn` = 1. Counter is held at 0. On `entry_enn` = 0, go to RELEASE. A key held across the re-grant is therefore never entered.
  - IDLE: on a valid key, load the candidate digit, set the counter to 1, go to PRESS.
  - PRESS: a matching valid sample increments the counter. When the counter reaches `DEBOUNCE_CYCLES`: shift the digit in, pulse `key_strobe`, go to RELEASE. A valid key with a different digit reloads the candidate and sets the counter to 1. A no-key sample returns to IDLE with no shift.
  - RELEASE: a no-key sample increments the counter and any valid key resets it to 0. When the counter reaches `DEBOUNCE_CYCLES`, go to IDLE.
- Shift on accept: `min_ones` <= `sec_tens`, `sec_tens` <= `sec_ones`, `sec_ones` <= digit. The old `min_ones` is discarded. No range clamping is applied; the timer block normalises SS > 59.
- `clear` zeroes all digits, including in DISABLED. If `clear` coincides with an accept, clear wins: digits become 0, `key_strobe` still pulses, and the FSM still goes to RELEASE.
- `entry_nonzero` is recomputed from the next-state digits and registered.

## Timing
- Reset values: FSM DISABLED, counter 0, all digits 0, `key_strobe` 0, `entry_nonzero` 0, `encoder_enablen` 1, `entry_timeout` 0, capture registers 0.
- Reset asserted mid-operation forces these values at the next edge. Any debounce in progress is lost.
- Press latency: the first valid sample is captured at edge k. The digit registers update at edge k+`DEBOUNCE_CYCLES`, and `key_strobe` is high in the cycle following that edge.
- Release: at least `DEBOUNCE_CYCLES` no-key samples are required before the next press counts. A minimum key-to-key period is 2·`DEBOUNCE_CYCLES`+1 cycles.
- `entry_enn` rising during PRESS aborts at the next edge with no shift and no strobe.
- Counter width is $clog2(`DEBOUNCE_CYCLES`+1). It saturates and never wraps.

## Configuration
- `KEYPAD_CTRL_TIMEOUT_EN` defined:
  - An idle counter of width $clog2(`TIMEOUT_CYCLES`+1) resets on each `key_strobe` and on `clear`.
  - It counts in IDLE only while `entry_nonzero` = 1.
  - On reaching `TIMEOUT_CYCLES`, `entry_timeout` pulses for 1 cycle. The counter then holds until the next reset event.
  - Digits are unchanged by a timeout.
- `KEYPAD_CTRL_TIMEOUT_EN` not defined: no `entry_timeout` port, no idle counter, and `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state enum (DISABLED, IDLE, PRESS, RELEASE);
  - `BCD_W` = 4;
  - the BCD digit typedef;
  - `BCD_MAX` = 9.
- Sub-module `keypad_debounce_cnt` is the saturating match counter, with inputs `inc`, `rst`, `load1` and outputs `count` and `done`.
- The FSM and digit register live in the top module.

## Test plan
1. Reset, then grant entry. Hold `bcd`=5, `data_valid`=1 for 6 cycles, then release for 5 cycles → one `key_strobe`, `sec_ones`=5, others 0, `entry_nonzero`=1.
2. Enter 1, 2, 3, then 4, each with a proper press and release → `min_ones`=2, `sec_tens`=3, `sec_ones`=4, and exactly 4 strobes.
3. Hold a key for 2 cycles, then `data_valid`=0 → no strobe, digits unchanged. Bounce 7→3 mid-press → only 3 is accepted.
4. Key held while `entry_enn`=1, then `entry_enn` falls with the key still held → no entry until the key has been released for 4 cycles and pressed again.
5. Assert `clear` in the same cycle as an accept → digits 0, `key_strobe`=1, `entry_nonzero`=0. Drive `bcd`=12 with `data_valid`=1 → ignored.
6. With `KEYPAD_CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20: enter 8 and wait → `entry_timeout` pulses exactly once, and `sec_ones` stays 8.
